// File: rtl/mul_arbiter_pkg.sv
// Shared types and defaults for the two-requester multiplier arbiter.
// Holds the one-hot FSM encoding and the parameter defaults.
package mul_arbiter_pkg;

    localparam int TIMEOUT_DEF = 12;
    localparam int OPW_DEF     = 8;
    localparam int STATE_W     = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 4'b0001,
        ISSUE = 4'b0010,
        WAIT  = 4'b0100,
        RESP  = 4'b1000
    } state_t;

endpackage

// File: rtl/mul_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone request wins outright,
// a tie goes to the requester that was not granted last.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = 1'b0;
        case (req)
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~last_grant;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/mul_arbiter.sv
// Arbitrates two signed-multiply requesters onto one shared Booth multiplier,
// with a bounded wait that aborts a stalled multiply with an error response.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int OPW     = OPW_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [OPW-1:0]   op_a0,
    input  logic [OPW-1:0]   op_b0,
    input  logic [OPW-1:0]   op_a1,
    input  logic [OPW-1:0]   op_b1,
    output logic [1:0]       ack,
    output logic [1:0]       done,
    output logic [2*OPW-1:0] result,
    output logic             err,
    output logic             busy,
    output logic             mul_start,
    output logic [OPW-1:0]   mul_a,
    output logic [OPW-1:0]   mul_b,
    input  logic             mul_done,
    input  logic [2*OPW-1:0] mul_result
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nxt;
    logic               owner;
    logic               last_grant;
    logic               winner;
    logic               valid;
    logic [OPW-1:0]     a_q;
    logic [OPW-1:0]     b_q;
    logic [2*OPW-1:0]   res_q;
    logic               err_q;
    logic [TW-1:0]      timer;
    logic               timed_out;

    rr_pick2 u_pick (
        .req        (req),
        .last_grant (last_grant),
        .winner     (winner),
        .valid      (valid)
    );

    assign timed_out = (timer >= T_LAST);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (valid) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (mul_done || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ack       = '0;
        done      = '0;
        result    = '0;
        err       = 1'b0;
        mul_start = 1'b0;
        mul_a     = '0;
        mul_b     = '0;
        busy      = (state != IDLE);
        if (state == ISSUE) begin
            ack[owner] = 1'b1;
            mul_start  = 1'b1;
        end
        if (state == ISSUE || state == WAIT) begin
            mul_a = a_q;
            mul_b = b_q;
        end
        if (state == RESP) begin
            done[owner] = 1'b1;
            result      = res_q;
            err         = err_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
            timer      <= '0;
        end else begin
            state <= state_nxt;
            unique case (state)
                IDLE: begin
                    if (valid) begin
                        owner <= winner;
                        a_q   <= winner ? op_a1 : op_a0;
                        b_q   <= winner ? op_b1 : op_b0;
                        res_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                ISSUE: timer <= '0;
                WAIT: begin
                    // completion beats a timeout landing in the same cycle
                    if (mul_done) begin
                        res_q <= mul_result;
                        err_q <= 1'b0;
                    end else if (timed_out) begin
                        res_q <= '0;
                        err_q <= 1'b1;
                    end
                    if (!timed_out) timer <= timer + TW'(1);
                end
                RESP:    last_grant <= owner;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed scoreboard bench for mul_arbiter with a behavioural
// shared multiplier whose response latency is set per step.
module tb_mul_arbiter;
    import mul_arbiter_pkg::*;

    localparam int TO = 12;
    localparam int W  = 8;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [1:0]     req = '0;
    logic [W-1:0]   op_a0 = '0, op_b0 = '0, op_a1 = '0, op_b1 = '0;
    logic [1:0]     ack, done;
    logic [2*W-1:0] result;
    logic           err, busy, mul_start;
    logic [W-1:0]   mul_a, mul_b;
    logic           mul_done = 1'b0;
    logic [2*W-1:0] mul_result = '0;

    typedef struct packed {
        logic [1:0]     who;
        logic [2*W-1:0] res;
        logic           err;
    } exp_t;

    exp_t         sb[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           mul_lat = 0;
    logic [1:0]   hold = '0;
    logic [W-1:0] alt_a0 = '0, alt_b0 = '0;
    int           inj_at = -1;
    logic [W-1:0] inj_a = '0, inj_b = '0;
    int           ack_cyc, done_cyc;
    logic         seen;

    always #5 clock = ~clock;

    mul_arbiter #(.TIMEOUT(TO), .OPW(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .op_a0      (op_a0),
        .op_b0      (op_b0),
        .op_a1      (op_a1),
        .op_b1      (op_b1),
        .ack        (ack),
        .done       (done),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .mul_start  (mul_start),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_result (mul_result)
    );

    // shared multiplier: pulses mul_done mul_lat cycles into WAIT
    initial forever begin
        logic [2*W-1:0] p;
        @(posedge clock);
        #1;
        if (mul_start === 1'b1 && mul_lat >= 0) begin
            p = $signed(mul_a) * $signed(mul_b);
            repeat (mul_lat + 1) @(posedge clock);
            #1;
            mul_result = p;
            mul_done   = 1'b1;
            @(posedge clock);
            #1;
            mul_done   = 1'b0;
            mul_result = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic serve(input int n, input int budget);
        int   got;
        logic bad;
        exp_t e;
        got = 0;
        bad = 1'b0;
        ack_cyc = -1;
        done_cyc = -1;
        for (int c = 1; c <= budget && got < n; c++) begin
            @(negedge clock);
            if (c == inj_at) begin
                op_a1 = inj_a;
                op_b1 = inj_b;
                req[1] = 1'b1;
            end
            if ((ack != 0 && done != 0) || !$onehot0(ack) || !$onehot0(done))
                bad = 1'b1;
            if (ack != 0 && ack_cyc < 0) ack_cyc = c;
            for (int k = 0; k < 2; k++) begin
                if (ack[k]) begin
                    if (!hold[k]) req[k] = 1'b0;
                    else if (k == 0) begin
                        op_a0 = alt_a0;
                        op_b0 = alt_b0;
                    end
                end
            end
            if (done != 0) begin
                got++;
                if (done_cyc < 0) done_cyc = c;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL unexpected_done observed=%0h expected=none", done);
                end else begin
                    e = sb.pop_front();
                    chk("owner", 32'(done), 32'(e.who));
                    chk("result", 32'(result), 32'(e.res));
                    chk("err", 32'(err), 32'(e.err));
                end
            end
        end
        chk("done_count", got, n);
        chk("ack_done_excl", 32'(bad), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_mul_start", 32'(mul_start), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("idle_busy", 32'(busy), 0);

        // contention from reset: 0, then 1, then 0 again
        mul_lat = 1;
        op_a0 = 8'd5;  op_b0 = 8'd6;
        alt_a0 = 8'hFE; alt_b0 = 8'd9;
        op_a1 = 8'hFD; op_b1 = 8'hFC;
        sb.push_back('{2'b01, 16'h001E, 1'b0});
        sb.push_back('{2'b10, 16'h000C, 1'b0});
        sb.push_back('{2'b01, 16'hFFEE, 1'b0});
        hold = 2'b11;
        req = 2'b11;
        serve(3, 80);
        req = 2'b00;
        hold = 2'b00;

        // single request, multiplier done two cycles into WAIT
        @(negedge clock);
        mul_lat = 2;
        op_a0 = 8'd3; op_b0 = 8'hFB;
        sb.push_back('{2'b01, 16'hFFF1, 1'b0});
        req = 2'b01;
        serve(1, 40);
        chk("single_ack_cyc", ack_cyc, 1);
        chk("single_done_cyc", done_cyc, 5);

        // minimum latency
        @(negedge clock);
        mul_lat = 0;
        op_a1 = 8'd7; op_b1 = 8'd9;
        sb.push_back('{2'b10, 16'h003F, 1'b0});
        req = 2'b10;
        serve(1, 40);
        chk("minlat_done_cyc", done_cyc, 3);

        // timeout: multiplier never answers
        @(negedge clock);
        mul_lat = -1;
        op_a1 = 8'd4; op_b1 = 8'd4;
        sb.push_back('{2'b10, 16'h0000, 1'b1});
        req = 2'b10;
        serve(1, 60);
        chk("timeout_done_cyc", done_cyc, TO + 2);

        // mul_done in the final WAIT cycle beats the timeout
        @(negedge clock);
        mul_lat = TO - 1;
        op_a0 = 8'hF9; op_b0 = 8'd11;
        sb.push_back('{2'b01, 16'hFFB3, 1'b0});
        req = 2'b01;
        serve(1, 60);
        chk("simul_done_cyc", done_cyc, TO + 2);

        // extremes, with requester 1 arriving mid-service
        @(negedge clock);
        mul_lat = 0;
        op_a0 = 8'h80; op_b0 = 8'h80;
        inj_a = 8'h7F; inj_b = 8'h80;
        inj_at = 2;
        sb.push_back('{2'b01, 16'h4000, 1'b0});
        sb.push_back('{2'b10, 16'hC080, 1'b0});
        req = 2'b01;
        serve(2, 60);
        inj_at = -1;

        // reset while in WAIT, late mul_done must be ignored
        @(negedge clock);
        mul_lat = 3;
        op_a0 = 8'd2; op_b0 = 8'd2;
        req = 2'b01;
        @(negedge clock);
        chk("rstw_ack", 32'(ack), 32'(2'b01));
        req = 2'b00;
        @(negedge clock);
        chk("rstw_busy_pre", 32'(busy), 1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_mul_a", 32'(mul_a), 0);
        seen = 1'b0;
        repeat (8) begin
            @(negedge clock);
            if (done != 0 || busy) seen = 1'b1;
        end
        chk("rstw_no_done", 32'(seen), 0);

        mul_lat = 1;
        op_a0 = 8'd6; op_b0 = 8'hF9;
        sb.push_back('{2'b01, 16'hFFD6, 1'b0});
        req = 2'b01;
        serve(1, 40);
        chk("post_rst_done_cyc", done_cyc, 4);
        chk("sb_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
